// File: rtl/alu_shift_seq.sv
// alu_shift_seq: sequences a single-operand rotate/shift through an external
// 8-bit ALU. A request is captured in IDLE. The operand is shifted into the
// ALU latches in LOAD, and the shifter carry-out is captured at the same time.
// The ALU result and zero flag are captured in EXEC. The response is then held
// in DONE until the consumer takes it. A reserved opcode skips the ALU
// entirely and returns an error response that echoes the operand.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_op[2:0]               0=RLC 1=RRC 2=RL 3=RR 4=SLA 5=SRA 6=SRL 7=reserved
//   req_data[7:0], req_cy     operand and carry-in
//   alu_op, alu_si, alu_sh    operand bus, shift-in bit, shift dir (1=L, 2=R)
//   alu_oe, alu_la, alu_lb    output select (1=shifter, 2=result), latch loads
//   alu_mode, alu_l, alu_h    {r,s,v,ne,ci} mode, low/high nibble phase
//   alu_shift_dbl             shifter carry-out
//   alu_result, alu_zero      ALU result and zero flag
//   rsp_valid/rsp_ready       response handshake (valid only in DONE)
//   rsp_data, rsp_z, rsp_cy, rsp_err   response payload
module alu_shift_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_data,
  input  logic       req_cy,
  output logic [7:0] alu_op,
  output logic       alu_si,
  output logic [1:0] alu_sh,
  output logic [1:0] alu_oe,
  output logic       alu_la,
  output logic       alu_lb,
  output logic [4:0] alu_mode,
  output logic       alu_l,
  output logic       alu_h,
  input  logic       alu_shift_dbl,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_z,
  output logic       rsp_cy,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_RLC = 3'd0,
    OP_RRC = 3'd1,
    OP_RL  = 3'd2,
    OP_RR  = 3'd3,
    OP_SLA = 3'd4,
    OP_SRA = 3'd5,
    OP_SRL = 3'd6,
    OP_RSV = 3'd7
  } op_t;

  localparam logic [4:0] MODE_SHIFT = 5'b11100;
  localparam logic [1:0] SH_NONE    = 2'd0;
  localparam logic [1:0] SH_LEFT    = 2'd1;
  localparam logic [1:0] SH_RIGHT   = 2'd2;
  localparam logic [1:0] OE_SHIFTER = 2'd1;
  localparam logic [1:0] OE_RESULT  = 2'd2;

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [7:0] opnd_q, opnd_d;
  logic       cyin_q, cyin_d;
  logic [7:0] data_q, data_d;
  logic       z_q, z_d;
  logic       cy_q, cy_d;
  logic       err_q, err_d;

  // Shift direction and shift-in bit depend only on the captured request.
  logic [1:0] sh_dir;
  logic       sh_in;

  always_comb begin
    sh_dir = SH_NONE;
    sh_in  = 1'b0;
    case (op_q)
      OP_RLC: begin sh_dir = SH_LEFT;  sh_in = opnd_q[7]; end
      OP_RRC: begin sh_dir = SH_RIGHT; sh_in = opnd_q[0]; end
      OP_RL:  begin sh_dir = SH_LEFT;  sh_in = cyin_q;    end
      OP_RR:  begin sh_dir = SH_RIGHT; sh_in = cyin_q;    end
      OP_SLA: begin sh_dir = SH_LEFT;  sh_in = 1'b0;      end
      OP_SRA: begin sh_dir = SH_RIGHT; sh_in = opnd_q[7]; end
      OP_SRL: begin sh_dir = SH_RIGHT; sh_in = 1'b0;      end
      default: begin sh_dir = SH_NONE; sh_in = 1'b0;      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    cyin_d   = cyin_q;
    data_d   = data_q;
    z_d      = z_q;
    cy_d     = cy_q;
    err_d    = err_q;

    alu_op   = '0;
    alu_si   = 1'b0;
    alu_sh   = SH_NONE;
    alu_oe   = '0;
    alu_la   = 1'b0;
    alu_lb   = 1'b0;
    alu_mode = '0;
    alu_l    = 1'b0;
    alu_h    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = op_t'(req_op);
          opnd_d = req_data;
          cyin_d = req_cy;
          if (op_t'(req_op) == OP_RSV) begin
            // Reserved opcode: the response is complete at acceptance.
            data_d  = req_data;
            cy_d    = req_cy;
            z_d     = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        alu_op   = opnd_q;
        alu_si   = sh_in;
        alu_sh   = sh_dir;
        alu_oe   = OE_SHIFTER;
        alu_la   = 1'b1;
        alu_lb   = 1'b1;
        alu_mode = MODE_SHIFT;
        alu_l    = 1'b1;
        cy_d     = alu_shift_dbl;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_oe   = OE_RESULT;
        alu_mode = MODE_SHIFT;
        alu_h    = 1'b1;
        data_d   = alu_result;
        z_d      = alu_zero;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_RLC;
      opnd_q  <= '0;
      cyin_q  <= 1'b0;
      data_q  <= '0;
      z_q     <= 1'b0;
      cy_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      cyin_q  <= cyin_d;
      data_q  <= data_d;
      z_q     <= z_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = data_q;
  assign rsp_z     = z_q;
  assign rsp_cy    = cy_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-004 SHALL have ports: req_op  in  3  0=RLC 1=RRC 2=RL 3=RR 4=SLA 5=SRA 6=SRL 7=reserved; req_data  in  8  operand; req_cy  in  1  carry flag in.
REQ-005 SHALL have ports: alu_op  out  8  operand bus; alu_si  out  1  shift-in bit; alu_sh  out  2  0=none 1=left 2=right.
REQ-006 SHALL have ports: alu_oe  out  2  0=none 1=shifter 2=result; alu_la, alu_lb  out  1 each  operand latch loads.
REQ-007 SHALL have ports: alu_mode  out  5  {r,s,v,ne,ci}; alu_l, alu_h  out  1 each  low/high nibble phase.
REQ-008 SHALL have ports: alu_shift_dbl  in  1  shifter carry-out; alu_result  in  8  ALU result; alu_zero  in  1  result-zero.
REQ-009 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  8; rsp_z  out  1; rsp_cy  out  1; rsp_err  out  1.

Function
REQ-010 SHALL implement FSM IDLE -> LOAD -> EXEC -> DONE -> IDLE; DONE -> IDLE only on rsp_ready; reserved op: IDLE -> DONE directly.
REQ-011 req_ready SHALL be 1 only in IDLE; req_op, req_data, req_cy SHALL be captured on acceptance and held internally.
REQ-012 LOAD (1 cycle): alu_op=operand, alu_oe=1, alu_la=alu_lb=1, alu_mode=5'b11100, alu_l=1, alu_h=0, alu_sh per op.
REQ-013 Shift direction: RLC/RL/SLA left; RRC/RR/SRA/SRL right.
REQ-014 alu_si SHALL be: RLC b[7]; RRC b[0]; RL, RR req_cy; SLA, SRL 0; SRA b[7].
REQ-015 In LOAD, alu_shift_dbl SHALL be registered as carry-out (b[7] for left, b[0] for right).
REQ-016 EXEC (1 cycle): alu_la=alu_lb=0, alu_oe=2, alu_mode=5'b11100, alu_l=0, alu_h=1, alu_sh=0, alu_op=0; alu_result and alu_zero SHALL be registered.
REQ-017 Outside LOAD/EXEC, all alu_* outputs SHALL be 0.
REQ-018 DONE: rsp_valid=1; rsp_data/rsp_z/rsp_cy/rsp_err SHALL be stable until rsp_ready is sampled high.
REQ-019 Latency: acceptance at edge N -> LOAD cycle N+1, EXEC N+2, rsp_valid high from N+3; with rsp_ready held high, the next request is accepted no earlier than edge N+4.
REQ-020 Reserved op: rsp_err=1, rsp_data=operand, rsp_cy=req_cy, rsp_z=0, no ALU cycles driven; otherwise rsp_err=0.
REQ-021 req_valid SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside DONE.

Reset
REQ-022 While reset_n=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_z=0, rsp_cy=0, rsp_err=0, all alu_* outputs=0.
REQ-023 Reset asserted in any state, including LOAD or EXEC, SHALL abort the operation immediately; no response is issued for it.
REQ-024 After reset_n rises, the first request SHALL be accepted on the first edge with req_valid=1.

Verification
REQ-025 RRC 0x01, req_cy=0 -> LOAD drives alu_si=1, alu_sh=2, alu_oe=1; response 0x80, z=0, cy=1, at N+3.
REQ-026 RL 0x80, req_cy=0 -> response 0x00, z=1, cy=1; RL 0x80, req_cy=1 -> response 0x01, z=0, cy=1.
REQ-027 SRA 0x81 -> response 0xC0, cy=1; SRL 0x81 -> response 0x40, cy=1; SLA 0x40 -> response 0x80, cy=0.
REQ-028 rsp_ready low for 3 cycles in DONE -> rsp_* held constant, req_ready=0, req_valid ignored; rsp_ready high -> IDLE next edge.
REQ-029 reset_n pulsed low during EXEC -> all outputs reach reset values asynchronously; no rsp_valid follows; new RLC 0x81 afterwards -> response 0x03, cy=1.
REQ-030 req_op=7, data 0x5A, req_cy=1 -> no ALU activity; response rsp_err=1, rsp_data=0x5A, rsp_cy=1, rsp_z=0.
